instruction_sequencer: RTL

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/tensor_core_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/instruction_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tensor_core_pkg.sv
// Shared opcode/opselect encodings, bus width and sequencer state type
// for the instruction sequencer and its FIFOs.
package tensor_core_pkg;

  localparam int unsigned BUS_WIDTH = 16;

  localparam logic [1:0] OPC_GENERIC = 2'b00;
  localparam logic [1:0] OPC_LOAD    = 2'b01;
  localparam logic [1:0] OPC_OPERATE = 2'b10;
  localparam logic [1:0] OPC_BURST   = 2'b11;

  localparam logic [1:0] SEL_NOP   = 2'b00;
  localparam logic [1:0] SEL_MOVE  = 2'b01;
  localparam logic [1:0] SEL_READ  = 2'b10;
  localparam logic [1:0] SEL_RESET = 2'b11;

  localparam int unsigned OP_WAIT_CYCLES    = 4;
  localparam int unsigned BURST_WRITE_WORDS = 5;
  localparam int unsigned BURST_READ_WORDS  = 9;

  typedef enum logic [1:0] {
    ISSUE,
    OP_WAIT,
    BW_DATA,
    BR_CAPTURE
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CAP);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Feeds queued instructions to the cpu, sequencing operate waits and bursts
// and collecting cpu_output into a result FIFO. Optional: SEQUENCER_STATS_EN.
module instruction_sequencer
  import tensor_core_pkg::*;
#(
  parameter int unsigned INSTR_DEPTH  = 8,
  parameter int unsigned RESULT_DEPTH = 16
) (
  input  logic               clock_in,
  input  logic               reset_in,
  input  logic               instr_valid_in,
  input  logic [15:0]        instr_data_in,
  output logic               instr_ready_out,
  output logic [15:0]        cpu_instruction_out,
  input  logic signed [7:0]  cpu_output_in,
  output logic               result_valid_out,
  output logic signed [7:0]  result_data_out,
  input  logic               result_ready_in,
  output logic               busy_out
`ifdef SEQUENCER_STATS_EN
  ,
  output logic [15:0]        issued_count_out,
  output logic [15:0]        stall_count_out
`endif
);
  localparam int unsigned IAW = $clog2(INSTR_DEPTH);
  localparam int unsigned RAW = $clog2(RESULT_DEPTH);

  seq_state_t           state, state_next;
  logic [3:0]           cnt, cnt_next;
  logic [BUS_WIDTH-1:0] head;
  logic [IAW:0]         instr_count;
  logic                 instr_full, instr_empty, instr_push, instr_pop;
  logic [RAW:0]         res_count;
  logic [RAW+1:0]       res_free;
  logic                 res_full, res_empty, res_push, res_pop;
  logic                 can_issue;
  logic [1:0]           opcode, opsel;

  assign instr_ready_out  = !instr_full;
  assign instr_push       = instr_valid_in && !instr_full;
  assign result_valid_out = !res_empty;
  assign res_pop          = result_ready_in && !res_empty;
  assign busy_out         = (state != ISSUE) || !instr_empty;
  assign opcode           = head[1:0];
  assign opsel            = head[3:2];

  // A pop in the issue cycle frees a slot in time for the capture edge.
  assign res_free = (RAW+2)'(RESULT_DEPTH) - (RAW+2)'(res_count) + (RAW+2)'(res_pop);

  sync_fifo #(.WIDTH(BUS_WIDTH), .DEPTH(INSTR_DEPTH)) u_instr_fifo (
    .clk   (clock_in),
    .rst_n (reset_in),
    .push  (instr_push),
    .din   (instr_data_in),
    .pop   (instr_pop),
    .dout  (head),
    .count (instr_count),
    .full  (instr_full),
    .empty (instr_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RESULT_DEPTH)) u_result_fifo (
    .clk   (clock_in),
    .rst_n (reset_in),
    .push  (res_push),
    .din   (cpu_output_in),
    .pop   (res_pop),
    .dout  (result_data_out),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  always_comb begin
    can_issue = 1'b0;
    case (opcode)
      OPC_GENERIC: can_issue = (opsel != SEL_READ) || !res_full || res_pop;
      OPC_BURST:   can_issue = head[2]
                     ? (instr_count >= (IAW+1)'(BURST_WRITE_WORDS + 1))
                     : (res_free >= (RAW+2)'(BURST_READ_WORDS));
      default:     can_issue = 1'b1;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state <= ISSUE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next          = state;
    cnt_next            = cnt;
    cpu_instruction_out = '0;
    instr_pop           = 1'b0;
    res_push            = 1'b0;
    case (state)
      ISSUE: begin
        // Every issue clears the wait counter, which also covers generic reset.
        if (!instr_empty && can_issue) begin
          cpu_instruction_out = head;
          instr_pop           = 1'b1;
          cnt_next            = '0;
          if (opcode == OPC_OPERATE)
            state_next = OP_WAIT;
          else if (opcode == OPC_BURST)
            state_next = head[2] ? BW_DATA : BR_CAPTURE;
          else if (opcode == OPC_GENERIC && opsel == SEL_READ)
            res_push = 1'b1;
        end
      end
      OP_WAIT: begin
        if (cnt == 4'(OP_WAIT_CYCLES - 1)) begin
          state_next = ISSUE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      BW_DATA: begin
        cpu_instruction_out = head;
        instr_pop           = 1'b1;
        if (cnt == 4'(BURST_WRITE_WORDS - 1)) begin
          state_next = ISSUE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      BR_CAPTURE: begin
        res_push = 1'b1;
        if (cnt == 4'(BURST_READ_WORDS - 1)) begin
          state_next = ISSUE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = ISSUE;
    endcase
  end

`ifdef SEQUENCER_STATS_EN
  logic stall;
  assign stall = (state == ISSUE) && !instr_empty && !can_issue;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      issued_count_out <= '0;
      stall_count_out  <= '0;
    end else begin
      if (instr_pop && issued_count_out != 16'hFFFF)
        issued_count_out <= issued_count_out + 1'b1;
      if (stall && stall_count_out != 16'hFFFF)
        stall_count_out <= stall_count_out + 1'b1;
    end
  end
`endif

endmodule
